// File: rtl/scarv_ccx_pkg.sv
// Shared types and constants for the scarv ccx memif arbiter.
package scarv_ccx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } arb_state_t;

  typedef logic arb_id_t;

  // s0 wins the first contention after reset.
  localparam arb_id_t CCX_ARB_RESET_LAST = 1'b1;

endpackage

// File: rtl/scarv_ccx_rr_arb2.sv
// Two-way requester pick with round-robin pointer.
// Define SCARV_CCX_MEMIF_ARB_FIXED_PRIO_EN for fixed priority (s0 always wins contention).
module scarv_ccx_rr_arb2
  import scarv_ccx_pkg::*;
(
  input  logic       g_clk,
  input  logic       g_reset,
  input  logic [1:0] req,
  input  logic       hold,
  input  logic       hold_id,
  input  logic       accept,
  output logic       sel_vld,
  output logic       sel_id
);

  arb_id_t contend_id;

`ifdef SCARV_CCX_MEMIF_ARB_FIXED_PRIO_EN
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{g_clk, g_reset, accept};
  assign contend_id       = 1'b0;
`else
  arb_id_t last_gnt;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      last_gnt <= CCX_ARB_RESET_LAST;
    end else if (accept) begin
      last_gnt <= sel_id;
    end
  end

  assign contend_id = ~last_gnt;
`endif

  always_comb begin
    sel_vld = hold | (|req);
    sel_id  = 1'b0;
    if (hold) begin
      sel_id = hold_id;
    end else if (&req) begin
      sel_id = contend_id;
    end else begin
      sel_id = req[1];
    end
  end

endmodule

// File: rtl/scarv_ccx_memif_arb.sv
// Two-into-one memif arbiter: fetch (s0) and load/store (s1) share port m.
// Fixed-priority variant selected by SCARV_CCX_MEMIF_ARB_FIXED_PRIO_EN.
module scarv_ccx_memif_arb
  import scarv_ccx_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,

  input  logic            s0_req,
  output logic            s0_gnt,
  input  logic            s0_wen,
  input  logic [DW/8-1:0] s0_strb,
  input  logic [DW-1:0]   s0_wdata,
  input  logic [AW-1:0]   s0_addr,
  output logic            s0_error,
  output logic [DW-1:0]   s0_rdata,

  input  logic            s1_req,
  output logic            s1_gnt,
  input  logic            s1_wen,
  input  logic [DW/8-1:0] s1_strb,
  input  logic [DW-1:0]   s1_wdata,
  input  logic [AW-1:0]   s1_addr,
  output logic            s1_error,
  output logic [DW-1:0]   s1_rdata,

  output logic            m_req,
  input  logic            m_gnt,
  output logic            m_wen,
  output logic [DW/8-1:0] m_strb,
  output logic [DW-1:0]   m_wdata,
  output logic [AW-1:0]   m_addr,
  input  logic            m_error,
  input  logic [DW-1:0]   m_rdata
);

  arb_state_t state_q, state_d;
  logic       arb_sel_vld;
  arb_id_t    sel_id;
  logic       sel_vld;
  logic       accept;
  logic       rsp_vld_q;
  arb_id_t    rsp_id_q;

  scarv_ccx_rr_arb2 u_pick (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .req     ({s1_req, s0_req}),
    .hold    (state_q != IDLE),
    .hold_id (state_q == HOLD1),
    .accept  (accept),
    .sel_vld (arb_sel_vld),
    .sel_id  (sel_id)
  );

  // Gate with reset so the combinational request path also clears immediately.
  assign sel_vld = arb_sel_vld & ~g_reset;
  assign accept  = m_req & m_gnt;

  always_comb begin
    m_req   = 1'b0;
    m_wen   = 1'b0;
    m_strb  = '0;
    m_wdata = '0;
    m_addr  = '0;
    if (sel_vld) begin
      m_req   = sel_id ? s1_req   : s0_req;
      m_wen   = sel_id ? s1_wen   : s0_wen;
      m_strb  = sel_id ? s1_strb  : s0_strb;
      m_wdata = sel_id ? s1_wdata : s0_wdata;
      m_addr  = sel_id ? s1_addr  : s0_addr;
    end
  end

  assign s0_gnt = sel_vld & ~sel_id & m_gnt;
  assign s1_gnt = sel_vld &  sel_id & m_gnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (arb_sel_vld && !m_gnt) state_d = sel_id ? HOLD1 : HOLD0;
      HOLD0, HOLD1: if (m_gnt) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q   <= IDLE;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_vld_q <= accept;
      if (accept) rsp_id_q <= sel_id;
    end
  end

  assign s0_rdata = (rsp_vld_q && !rsp_id_q) ? m_rdata : '0;
  assign s0_error = rsp_vld_q && !rsp_id_q && m_error;
  assign s1_rdata = (rsp_vld_q &&  rsp_id_q) ? m_rdata : '0;
  assign s1_error = rsp_vld_q &&  rsp_id_q && m_error;

  // A held requester must not withdraw before its grant.
  a_hold_req : assert property (@(posedge g_clk) disable iff (g_reset)
    ((state_q == HOLD0) |-> s0_req) and ((state_q == HOLD1) |-> s1_req));

endmodule
